// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Display values are taken over valid/ready and committed only at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              digit_q, digit_d;
  logic                    fs_q, fs_d;
  logic                    ready_q, ready_d;
  logic                    boundary_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;

  // Bit i set when digit i is a leading zero (nibbles NUM_DIGITS-1..i all zero).
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (v[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  assign lz_mask_s  = (LZ_SUPPRESS != 0) ? lz_mask(disp_q) : '0;
  assign boundary_s = (state_q == ST_SHOW) && (cnt_q == SLOT_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // A capture on the boundary cycle is only possible with nothing pending, so it never bypasses.
    if (boundary_s && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end else if (load_valid && ready_q) begin
      pend_d    = load_data;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    // Display outputs trail the scan state by one register stage.
    an_d    = '1;
    digit_d = disp_q[{idx_q, 2'b00} +: 4];
    fs_d    = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    ready_d = !pending_d;
    if ((state_q == ST_SHOW) && !lz_mask_s[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end else begin
      an_d = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      digit_q   <= 4'd0;
      fs_q      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
      fs_q      <= fs_d;
      ready_q   <= ready_d;
    end
  end

  assign an          = an_q;
  assign digit       = digit_q;
  assign frame_start = fs_q;
  assign load_ready  = ready_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a NUM_DIGITS common-anode seven-segment display.
- Shares a single combinational BCD-to-segment decoder across all digits: drives its 4-bit digit input and the active-low anode enables.
- Accepts new display values over a valid/ready handshake. Commits them only at a frame boundary, so a frame never shows a mix of old and new digits.
- Sits between the counter/datapath logic and the board-level segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; 2..8
SLOT_CYCLES, 100000, clock cycles per digit slot (blank + show); must exceed BLANK_CYCLES
BLANK_CYCLES, 1000, anti-ghosting cycles at slot start with all anodes off; >=1
LZ_SUPPRESS, 1, 1 = blank leading zero digits; digit 0 is always shown

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
load_valid  in  1  producer has a new display value
load_ready  out  1  controller can accept a value
load_data  in  4*NUM_DIGITS  packed BCD; nibble i = digit i; digit 0 = least significant
digit  out  4  BCD nibble to the segment decoder
an  out  NUM_DIGITS  anode enables, active-low; bit i = digit i
frame_start  out  1  one-cycle pulse at the start of each scan frame

Behaviour:
- Reset values (all outputs registered):
  - an = all ones, digit = 0, frame_start = 0, load_ready = 1.
  - Internal: state = BLANK, idx = 0, slot counter = 0, disp_reg = 0, pend_reg = 0, pending = 0.
- FSM states BLANK and SHOW. The slot counter counts 0..SLOT_CYCLES-1 and restarts at 0 on each slot.
- BLANK:
  - an = all ones; digit = disp_reg nibble idx, so the decoder settles before the anode turns on.
  - Lasts BLANK_CYCLES cycles, then moves to SHOW.
- SHOW:
  - an[idx] = 0, all other bits 1. Exception: an stays all ones when the digit is suppressed (see leading-zero rule).
  - Lasts SLOT_CYCLES-BLANK_CYCLES cycles.
  - At the end of SHOW, idx increments and the FSM returns to BLANK. idx wraps NUM_DIGITS-1 -> 0.
- Frame boundary (last SHOW cycle of idx = NUM_DIGITS-1):
  - If pending = 1: disp_reg <= pend_reg and pending <= 0.
  - frame_start = 1 on the first BLANK cycle of idx 0, including the first slot after reset.
- Handshake:
  - load_ready = !pending.
  - A transfer occurs on a rising edge with load_valid & load_ready: pend_reg <= load_data, pending <= 1. load_ready is 0 from the next cycle.
  - The new value appears from the next frame; it is never applied mid-frame.
- Simultaneous events: a transfer on the boundary cycle with pending = 0 is captured into pend_reg and committed at the following boundary. No same-cycle bypass into disp_reg.
- Producer rule: while load_ready = 0, load_valid may stay high and load_data must stay stable. The controller ignores load_data until ready.
- Leading-zero rule (LZ_SUPPRESS = 1):
  - Digit i > 0 is suppressed if disp_reg nibbles NUM_DIGITS-1 down to i are all zero.
  - A suppressed digit keeps its slot timing but an stays all ones. Digit 0 is never suppressed.
  - With LZ_SUPPRESS = 0 every digit is shown.
- Nibble values 10..15 are passed through unchanged. Decoder behaviour for them is defined by the decoder, not this block.
- Reset asserted mid-slot or mid-handshake: everything returns to reset values immediately (asynchronous). Any pending value is discarded.
- Counter widths: slot counter = clog2(SLOT_CYCLES); idx = clog2(NUM_DIGITS), minimum 1 bit.

Test Plan:
1. Params NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, LZ_SUPPRESS=0. Release reset, no load -> an sequence 1111 x2, 1110 x6, 1111 x2, 1101 x6, ... up to 0111; digit=0 throughout; frame_start pulses every 32 cycles, first on cycle 0 after reset.
2. Load 0x1234 mid-frame (during idx 1) -> load_ready drops the cycle after acceptance; the current frame still shows 0; the next frame shows digits 4,3,2,1 on idx 0..3; load_ready returns to 1 after the boundary.
3. Back-to-back loads 0x1111 then 0x2222 held valid -> the second is accepted only after the first commits; each value is displayed for at least one full frame; no frame shows mixed nibbles.
4. LZ_SUPPRESS=1, load 0x0050 -> idx 3 and 2 show an=1111; idx 1 shows an=1101 with digit 5; idx 0 shows an=1110 with digit 0. Load 0x0000 -> only digit 0 is lit.
5. load_valid asserted on the exact boundary cycle with pending=0 -> the value commits at the following boundary, 32 cycles later, not immediately.
6. Assert reset during SHOW of idx 2 with a pending value -> an=1111, load_ready=1, disp_reg=0 asynchronously; after release, scanning restarts at idx 0 with a frame_start pulse.
